// File: rtl/bsg_round_robin_n_to_1_gather.sv
// rtl/bsg_round_robin_n_to_1_gather.sv - round-robin n-to-1 gather with registered output and source tag
module bsg_round_robin_n_to_1_gather #(
  parameter int width_p  = 8,
  parameter int num_in_p = 2,
  parameter int strict_p = 1,
  localparam int lg_p    = (num_in_p > 2) ? $clog2(num_in_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_in_p*width_p-1:0]  data_i,
  input  logic [num_in_p-1:0]          valid_i,
  output logic [num_in_p-1:0]          ready_o,
  output logic [width_p-1:0]           data_o,
  output logic [lg_p-1:0]              tag_o,
  output logic                         valid_o,
  input  logic                         ready_i
);

  localparam logic [lg_p:0] num_w = (lg_p+1)'(num_in_p);

  // Operands are always < num_in_p, so one conditional subtract gives the modulo.
  function automatic logic [lg_p-1:0] wrap_add(input logic [lg_p-1:0] a, input logic [lg_p-1:0] b);
    logic [lg_p:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= num_w) sum = sum - num_w;
    return sum[lg_p-1:0];
  endfunction

  logic [lg_p-1:0]    ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic [width_p-1:0] data_q, data_d;
  logic [lg_p-1:0]    tag_q, tag_d;

  logic               load_en;
  logic               found;
  logic               hs;
  logic [lg_p-1:0]    sel;
  logic [width_p-1:0] sel_data;

  assign load_en = ~valid_q | ready_i;

  // Reverse scan so the lane closest to ptr_q (in circular order) wins.
  always_comb begin
    sel   = ptr_q;
    found = 1'b1;
    if (strict_p == 0) begin
      found = 1'b0;
      for (int i = num_in_p - 1; i >= 0; i--) begin
        if (valid_i[wrap_add(ptr_q, lg_p'(i))]) begin
          found = 1'b1;
          sel   = wrap_add(ptr_q, lg_p'(i));
        end
      end
    end
  end

  always_comb begin
    ready_o  = '0;
    sel_data = '0;
    for (int k = 0; k < num_in_p; k++) begin
      if (lg_p'(k) == sel) begin
        sel_data = data_i[k*width_p +: width_p];
        if (reset_n_i & load_en & found) ready_o[k] = 1'b1;
      end
    end
  end

  assign hs = |(valid_i & ready_o);

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (hs) begin
      data_d  = sel_data;
      tag_d   = sel;
      valid_d = 1'b1;
      ptr_d   = wrap_add(sel, lg_p'(1));
    end else if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign data_o  = data_q;
  assign tag_o   = tag_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_bsg_round_robin_n_to_1_gather.sv
// tb/tb_bsg_round_robin_n_to_1_gather.sv - bench for bsg_round_robin_n_to_1_gather
module tb_bsg_round_robin_n_to_1_gather;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // two lanes, strict
  logic        rst2, vo2, ri2;
  logic [1:0]  v2, ro2;
  logic [15:0] d2;
  logic [7:0]  do2;
  logic [0:0]  tag2;
  // three lanes, strict
  logic        rst3, vo3, ri3;
  logic [2:0]  v3, ro3;
  logic [23:0] d3;
  logic [7:0]  do3;
  logic [1:0]  tag3;
  // four lanes, work-conserving
  logic        rst4, vo4, ri4;
  logic [3:0]  v4, ro4;
  logic [31:0] d4;
  logic [7:0]  do4;
  logic [1:0]  tag4;

  bsg_round_robin_n_to_1_gather #(.width_p(8), .num_in_p(2), .strict_p(1)) u2 (
    .clk_i(clk), .reset_n_i(rst2), .data_i(d2), .valid_i(v2), .ready_o(ro2),
    .data_o(do2), .tag_o(tag2), .valid_o(vo2), .ready_i(ri2));
  bsg_round_robin_n_to_1_gather #(.width_p(8), .num_in_p(3), .strict_p(1)) u3 (
    .clk_i(clk), .reset_n_i(rst3), .data_i(d3), .valid_i(v3), .ready_o(ro3),
    .data_o(do3), .tag_o(tag3), .valid_o(vo3), .ready_i(ri3));
  bsg_round_robin_n_to_1_gather #(.width_p(8), .num_in_p(4), .strict_p(0)) u4 (
    .clk_i(clk), .reset_n_i(rst4), .data_i(d4), .valid_i(v4), .ready_o(ro4),
    .data_o(do4), .tag_o(tag4), .valid_o(vo4), .ready_i(ri4));

  typedef struct {
    logic        rst_n;
    logic [1:0]  v;
    logic [15:0] d;
    logic        ri;
    logic [1:0]  e_ready;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_tag;
  } vec_t;

  vec_t vecs[21];

  // Spec-level model: pointer, output register, grant by circular search (or fixed pointer when strict).
  task automatic model_step(input int n, input bit strict_m, input bit rst_n, input logic [31:0] v,
                            input logic [31:0] d, input bit ri, inout int ptr, inout bit mv,
                            inout int md, inout int mt, output logic [31:0] er);
    int grant;
    er = 0;
    if (!rst_n) begin
      ptr = 0; mv = 0; md = 0; mt = 0;
      return;
    end
    grant = -1;
    if (!mv || ri) begin
      if (strict_m) grant = ptr;
      else begin
        for (int off = 0; off < n; off++) begin
          if (grant < 0 && v[(ptr + off) % n]) grant = (ptr + off) % n;
        end
      end
    end
    if (grant >= 0) er = 32'(1) << grant;
    if (grant >= 0 && v[grant]) begin
      md  = int'((d >> (8 * grant)) & 32'hFF);
      mt  = grant;
      mv  = 1;
      ptr = (grant + 1) % n;
    end else if (mv && ri) begin
      mv = 0;
    end
  endtask

  task automatic step3(input string nm, input logic [2:0] v, input logic [23:0] d, input logic [2:0] er,
                       input logic ev, input logic [7:0] ed, input logic [1:0] et);
    rst3 = 1'b1; v3 = v; d3 = d; ri3 = 1'b1;
    #2;
    chk({nm, "_ready"}, 32'(ro3), 32'(er));
    @(posedge clk); #1;
    chk({nm, "_valid"}, 32'(vo3), 32'(ev));
    chk({nm, "_data"}, 32'(do3), 32'(ed));
    chk({nm, "_tag"}, 32'(tag3), 32'(et));
  endtask

  task automatic step4(input string nm, input logic [3:0] v, input logic [31:0] d, input logic [3:0] er,
                       input logic ev, input logic [7:0] ed, input logic [1:0] et);
    rst4 = 1'b1; v4 = v; d4 = d; ri4 = 1'b1;
    #2;
    chk({nm, "_ready"}, 32'(ro4), 32'(er));
    @(posedge clk); #1;
    chk({nm, "_valid"}, 32'(vo4), 32'(ev));
    chk({nm, "_data"}, 32'(do4), 32'(ed));
    chk({nm, "_tag"}, 32'(tag4), 32'(et));
  endtask

  int p3, md3, mt3, p4, md4, mt4;
  bit mv3, mv4;
  logic [31:0] er3, er4;

  initial begin
    rst2 = 0; v2 = 0; d2 = 0; ri2 = 0;
    rst3 = 0; v3 = 0; d3 = 0; ri3 = 0;
    rst4 = 0; v4 = 0; d4 = 0; ri4 = 0;

    // rst_n, valid, data{l1,l0}, ready_i | ready_o before edge, valid/data/tag after edge
    vecs[0]  = '{1'b0, 2'b00, 16'h0000, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 16'h0000, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 16'h0000, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 16'h0000, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 16'hB100, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 2'b10, 16'hB100, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 16'hB100, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 2'b11, 16'hB1A0, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0};
    vecs[8]  = '{1'b1, 2'b10, 16'hB1A0, 1'b1, 2'b10, 1'b1, 8'hB1, 1'b1};
    vecs[9]  = '{1'b1, 2'b00, 16'hB1A0, 1'b1, 2'b01, 1'b0, 8'hB1, 1'b1};
    vecs[10] = '{1'b1, 2'b01, 16'h005C, 1'b0, 2'b01, 1'b1, 8'h5C, 1'b0};
    vecs[11] = '{1'b1, 2'b11, 16'h775C, 1'b0, 2'b00, 1'b1, 8'h5C, 1'b0};
    vecs[12] = '{1'b1, 2'b11, 16'h775C, 1'b0, 2'b00, 1'b1, 8'h5C, 1'b0};
    vecs[13] = '{1'b1, 2'b11, 16'h775C, 1'b0, 2'b00, 1'b1, 8'h5C, 1'b0};
    vecs[14] = '{1'b1, 2'b11, 16'h775C, 1'b0, 2'b00, 1'b1, 8'h5C, 1'b0};
    vecs[15] = '{1'b1, 2'b10, 16'h775C, 1'b1, 2'b10, 1'b1, 8'h77, 1'b1};
    vecs[16] = '{1'b1, 2'b01, 16'h773E, 1'b1, 2'b01, 1'b1, 8'h3E, 1'b0};
    vecs[17] = '{1'b1, 2'b10, 16'h993E, 1'b0, 2'b00, 1'b1, 8'h3E, 1'b0};
    vecs[18] = '{1'b0, 2'b10, 16'h993E, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[19] = '{1'b1, 2'b10, 16'h9900, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
    vecs[20] = '{1'b1, 2'b11, 16'h9944, 1'b1, 2'b01, 1'b1, 8'h44, 1'b0};

    for (int i = 0; i < 21; i++) begin
      rst2 = vecs[i].rst_n; v2 = vecs[i].v; d2 = vecs[i].d; ri2 = vecs[i].ri;
      #2;
      chk($sformatf("vec%0d_ready", i), 32'(ro2), 32'(vecs[i].e_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(vo2), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i), 32'(do2), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_tag", i), 32'(tag2), 32'(vecs[i].e_tag));
    end

    // three lanes all valid: tags rotate 0,1,2,0,1,2 with no bubble
    for (int j = 0; j < 6; j++) begin
      step3($sformatf("wrap%0d", j), 3'b111, 24'h323130, 3'(1 << (j % 3)),
            1'b1, 8'(8'h30 + j % 3), 2'(j % 3));
    end

    // work-conserving skip over idle lanes
    step4("skip0", 4'b0001, 32'h00000040, 4'b0001, 1'b1, 8'h40, 2'd0);
    step4("skip1", 4'b1000, 32'h43000000, 4'b1000, 1'b1, 8'h43, 2'd3);
    step4("skip2", 4'b0101, 32'h00520050, 4'b0001, 1'b1, 8'h50, 2'd0);
    step4("skip3", 4'b0100, 32'h00520000, 4'b0100, 1'b1, 8'h52, 2'd2);
    step4("skip4", 4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h52, 2'd2);

    p3 = 0; mv3 = 0; md3 = 0; mt3 = 0;
    p4 = 0; mv4 = 0; md4 = 0; mt4 = 0;
    for (int c = 0; c < 400; c++) begin
      rst3 = (c == 0) ? 1'b0 : ($urandom_range(39) != 0);
      rst4 = (c == 0) ? 1'b0 : ($urandom_range(39) != 0);
      v3 = 3'($urandom); d3 = 24'($urandom); ri3 = ($urandom_range(3) != 0);
      v4 = 4'($urandom); d4 = $urandom;      ri4 = ($urandom_range(3) != 0);
      model_step(3, 1'b1, rst3, 32'(v3), 32'(d3), ri3, p3, mv3, md3, mt3, er3);
      model_step(4, 1'b0, rst4, 32'(v4), d4, ri4, p4, mv4, md4, mt4, er4);
      #2;
      chk("rnd3_ready", 32'(ro3), er3);
      chk("rnd4_ready", 32'(ro4), er4);
      chk("rnd3_ready_onehot0", 32'($onehot0(ro3)), 32'(1));
      chk("rnd4_ready_onehot0", 32'($onehot0(ro4)), 32'(1));
      chk("rnd3_single_hs", 32'($countones(v3 & ro3) <= 1), 32'(1));
      chk("rnd4_single_hs", 32'($countones(v4 & ro4) <= 1), 32'(1));
      @(posedge clk); #1;
      chk("rnd3_valid", 32'(vo3), 32'(mv3));
      chk("rnd4_valid", 32'(vo4), 32'(mv4));
      if (mv3) begin
        chk("rnd3_data", 32'(do3), 32'(md3));
        chk("rnd3_tag", 32'(tag3), 32'(mt3));
        chk("rnd3_tag_range", 32'(tag3 < 2'd3), 32'(1));
      end
      if (mv4) begin
        chk("rnd4_data", 32'(do4), 32'(md4));
        chk("rnd4_tag", 32'(tag4), 32'(mt4));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
